// File: rtl/apb_uart_fifo.sv
// rtl/apb_uart_fifo.sv - APB UART with TX/RX FIFOs, parity, sticky errors and level IRQ

// Circular buffer with wrapping pointers and an occupancy count.
module apb_uart_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  // A push into a full buffer is accepted only when the same edge frees a slot.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q];

  // Storage array, no reset needed since the count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module apb_uart_fifo #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  RX,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  Tx,
  output logic                  IRQ
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [4:0] A_TXDATA = 5'h00;
  localparam logic [4:0] A_RXDATA = 5'h04;
  localparam logic [4:0] A_STATUS = 5'h08;
  localparam logic [4:0] A_CTRL   = 5'h0C;
  localparam logic [4:0] A_BAUD   = 5'h10;

  // Register file
  logic [6:0]  ctrl_q;
  logic [15:0] baud_q;
  logic        overrun_q, parity_err_q, frame_err_q;
  logic        irq_q, irq_d;

  // FIFO interface
  logic       tx_full, tx_empty, tx_pop, tx_push;
  logic       rx_full, rx_empty, rx_pop;
  logic [7:0] tx_head, rx_head;

  // APB decode
  logic                  acc, wr_acc, rd_acc, apb_err;
  logic [4:0]            addr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  status_w, ctrl_w, baud_w;
  logic [6:0]            status;

  // TX engine
  state_t      tx_state_q;
  logic [15:0] tx_cnt_q, tx_div_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_sh_q;
  logic        tx_par_en_q, tx_par_bit_q, tx_q;
  logic        tx_tick;

  // RX engine
  logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
  state_t      rx_state_q;
  logic [15:0] rx_cnt_q, rx_div_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q, rx_byte_q;
  logic        rx_par_en_q, rx_par_odd_q;
  logic        rx_push_q, rx_perr_q, rx_ferr_q, rx_ovr;
  logic        rx_tick;

  logic unused_bits;
  assign unused_bits = ^{PADDR[ADDR_WIDTH-1:5], PWDATA[DATA_WIDTH-1:16]};

  assign acc    = PSELx & PENABLE;
  assign wr_acc = acc & PWRITE;
  assign rd_acc = acc & ~PWRITE;
  assign addr   = PADDR[4:0];
  assign PREADY = 1'b1;

  assign status = {frame_err_q, parity_err_q, overrun_q, rx_empty, rx_full, tx_empty, tx_full};

  // Classify the current access; an erroring access has no side-effect.
  always_comb begin
    apb_err = 1'b0;
    if (acc) begin
      case (addr)
        A_TXDATA: apb_err = ~PWRITE | tx_full;
        A_RXDATA: apb_err = PWRITE | rx_empty;
        A_STATUS, A_CTRL, A_BAUD: apb_err = 1'b0;
        default:  apb_err = 1'b1;
      endcase
    end
  end

  assign tx_push  = wr_acc & (addr == A_TXDATA) & ~apb_err;
  assign rx_pop   = rd_acc & (addr == A_RXDATA) & ~apb_err;
  assign status_w = wr_acc & (addr == A_STATUS);
  assign ctrl_w   = wr_acc & (addr == A_CTRL);
  assign baud_w   = wr_acc & (addr == A_BAUD);

  // Read mux: zero outside a successful read access.
  always_comb begin
    rdata = '0;
    if (rd_acc & ~apb_err) begin
      case (addr)
        A_RXDATA: rdata[7:0]  = rx_head;
        A_STATUS: rdata[6:0]  = status;
        A_CTRL:   rdata[6:0]  = ctrl_q;
        A_BAUD:   rdata[15:0] = baud_q;
        default:  rdata = '0;
      endcase
    end
  end

  assign PRDATA  = PRESET ? '0 : rdata;
  assign PSLVERR = apb_err & ~PRESET;

  apb_uart_fifo_buf #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .push_i  (tx_push),
    .data_i  (PWDATA[7:0]),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  // A byte arriving at a full RX FIFO is lost unless software reads on the same edge.
  assign rx_ovr = rx_push_q & rx_full & ~rx_pop;

  apb_uart_fifo_buf #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .push_i  (rx_push_q),
    .data_i  (rx_byte_q),
    .pop_i   (rx_pop),
    .data_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // Control registers and sticky error flags; a hardware set beats a W1C.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_q       <= '0;
      baud_q       <= DIV_RESET;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (ctrl_w) ctrl_q <= PWDATA[6:0];
      if (baud_w) baud_q <= PWDATA[15:0];
      overrun_q    <= rx_ovr    | (overrun_q    & ~(status_w & PWDATA[4]));
      parity_err_q <= rx_perr_q | (parity_err_q & ~(status_w & PWDATA[5]));
      frame_err_q  <= rx_ferr_q | (frame_err_q  & ~(status_w & PWDATA[6]));
    end
  end

  assign irq_d = (ctrl_q[4] & ~rx_empty) | (ctrl_q[5] & tx_empty) |
                 (ctrl_q[6] & (overrun_q | parity_err_q | frame_err_q));

  // Interrupt output is registered, one cycle behind its cause.
  always_ff @(posedge PCLK) begin
    if (PRESET) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end
  assign IRQ = irq_q;

  // The TX engine takes the FIFO head only while idle; tx_en gates new frames only.
  assign tx_pop  = (tx_state_q == S_IDLE) & ctrl_q[0] & ~tx_empty;
  assign tx_tick = (tx_cnt_q == tx_div_q);

  // TX frame sequencer with a registered serial output.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_state_q   <= S_IDLE;
      tx_cnt_q     <= '0;
      tx_div_q     <= '0;
      tx_bit_q     <= '0;
      tx_sh_q      <= '0;
      tx_par_en_q  <= 1'b0;
      tx_par_bit_q <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (tx_pop) begin
            tx_state_q   <= S_START;
            tx_q         <= 1'b0;
            tx_sh_q      <= tx_head;
            tx_div_q     <= baud_q;
            tx_cnt_q     <= '0;
            tx_par_en_q  <= ctrl_q[2];
            tx_par_bit_q <= (^tx_head) ^ ctrl_q[3];
          end
        end
        S_START: begin
          if (tx_tick) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_sh_q[0];
            tx_state_q <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (tx_tick) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              if (tx_par_en_q) begin
                tx_state_q <= S_PARITY;
                tx_q       <= tx_par_bit_q;
              end else begin
                tx_state_q <= S_STOP;
                tx_q       <= 1'b1;
              end
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_q     <= tx_sh_q[1];
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        S_PARITY: begin
          if (tx_tick) begin
            tx_cnt_q   <= '0;
            tx_state_q <= S_STOP;
            tx_q       <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (tx_tick) begin
            tx_cnt_q   <= '0;
            tx_state_q <= S_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        default: begin
          tx_state_q <= S_IDLE;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end
  assign Tx = tx_q;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign rx_fall = rx_s3_q & ~rx_s2_q;
  assign rx_tick = (rx_cnt_q == rx_div_q);

  // RX frame sequencer; push/error strobes are registered one-cycle pulses.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_div_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_byte_q    <= '0;
      rx_par_en_q  <= 1'b0;
      rx_par_odd_q <= 1'b0;
      rx_push_q    <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      rx_perr_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      case (rx_state_q)
        S_IDLE: begin
          if (ctrl_q[1] & rx_fall) begin
            rx_state_q   <= S_START;
            rx_cnt_q     <= '0;
            rx_div_q     <= baud_q;
            rx_par_en_q  <= ctrl_q[2];
            rx_par_odd_q <= ctrl_q[3];
          end
        end
        S_START: begin
          // Half a bit period after the edge: confirm a real start bit.
          if (rx_cnt_q == (rx_div_q >> 1)) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            if (rx_s2_q) rx_state_q <= S_IDLE;
            else         rx_state_q <= S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (rx_tick) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= rx_par_en_q ? S_PARITY : S_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        S_PARITY: begin
          if (rx_tick) begin
            rx_cnt_q   <= '0;
            rx_perr_q  <= rx_s2_q ^ (^rx_sh_q) ^ rx_par_odd_q;
            rx_state_q <= S_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (rx_tick) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_IDLE;
            if (rx_s2_q) begin
              rx_push_q <= 1'b1;
              rx_byte_q <= rx_sh_q;
            end else begin
              rx_ferr_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_uart_fifo.sv
// tb/tb_apb_uart_fifo.sv - scoreboard bench for apb_uart_fifo with serial and APB monitors

module tb_apb_uart_fifo;
  localparam int DEPTH = 16;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSELx = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, Tx, IRQ;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        rx_line;

  assign rx_line = loop_en ? Tx : rx_drv;

  apb_uart_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd867)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .RX(rx_line), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .Tx(Tx), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_data;
    logic [7:0]  addr;
  } apb_exp_t;

  apb_exp_t   apb_q[$];
  logic [7:0] tx_exp_q[$];
  int         tx_done = 0;
  bit         tx_mon_en = 1'b1;
  int         m_div = 3;
  bit         m_par_en = 1'b0;
  bit         m_par_odd = 1'b0;

  // Reference model state
  int         m_tx_cnt = 0;
  logic [7:0] rx_model[$];
  bit         m_ovr = 1'b0, m_perr = 1'b0, m_ferr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] st_exp();
    return {25'd0, m_ferr, m_perr, m_ovr, (rx_model.size() == 0), (rx_model.size() == DEPTH),
            (m_tx_cnt == 0), (m_tx_cnt == DEPTH)};
  endfunction

  function automatic void rx_model_push(input logic [7:0] b);
    if (rx_model.size() < DEPTH) rx_model.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  function automatic logic par_of(input logic [7:0] b, input bit odd);
    return logic'((($countones(b) % 2) != 0) ^ odd);
  endfunction

  task automatic apb(input logic [7:0] addr, input bit wr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input bit exp_err, input bit chk_data);
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    apb_q.push_back('{rdata: exp_rdata, err: exp_err, chk_data: chk_data, addr: addr});
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data, input bit err);
    apb(addr, 1'b1, data, 32'd0, err, 1'b1);
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input bit err);
    apb(addr, 1'b0, 32'd0, exp, err, !err);
  endtask

  task automatic wait_tx(input int target, input int budget);
    int n;
    n = 0;
    while (tx_done < target && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    check("tx frames completed", tx_done, target);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pe, input bit odd,
                            input bit bad_par, input bit stop_lvl);
    logic lv [11];
    int   n;
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[i+1] = b[i];
    n = 9;
    if (pe) begin
      lv[9] = par_of(b, odd) ^ bad_par;
      n = 10;
    end
    lv[n] = stop_lvl;
    n++;
    for (int i = 0; i < n; i++) begin
      rx_drv = lv[i];
      repeat (m_div + 1) @(negedge PCLK);
    end
    rx_drv = 1'b1;
    repeat (2 * (m_div + 1)) @(negedge PCLK);
  endtask

  // APB monitor: every access cycle is compared against the oldest expectation.
  initial begin
    apb_exp_t e;
    forever begin
      @(negedge PCLK);
      #2;
      if (PSELx && PENABLE) begin
        if (apb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL apb unexpected access at addr 0x%0h", PADDR);
        end else begin
          e = apb_q.pop_front();
          check($sformatf("apb 0x%0h pslverr", e.addr), {31'd0, PSLVERR}, {31'd0, e.err});
          check($sformatf("apb 0x%0h pready", e.addr), {31'd0, PREADY}, 32'd1);
          if (e.chk_data) check($sformatf("apb 0x%0h prdata", e.addr), PRDATA, e.rdata);
        end
      end
    end
  end

  // Serial TX monitor: each frame must hold every level for exactly m_div+1 cycles.
  initial begin
    logic [7:0] b;
    logic       lvl [11];
    int         nb;
    bit         bad, aborted;
    forever begin
      @(negedge PCLK);
      if (tx_mon_en && !PRESET && Tx === 1'b0) begin
        if (tx_exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx unexpected frame: got start bit, expected idle");
          repeat (11 * (m_div + 1)) @(negedge PCLK);
        end else begin
          b = tx_exp_q.pop_front();
          lvl[0] = 1'b0;
          for (int i = 0; i < 8; i++) lvl[i+1] = b[i];
          nb = 9;
          if (m_par_en) begin
            lvl[9] = par_of(b, m_par_odd);
            nb = 10;
          end
          lvl[nb] = 1'b1;
          nb++;
          bad = 1'b0;
          aborted = 1'b0;
          for (int bi = 0; bi < nb; bi++) begin
            for (int s = 0; s <= m_div; s++) begin
              if (!(bi == 0 && s == 0)) @(negedge PCLK);
              if (!tx_mon_en) aborted = 1'b1;
              if (!aborted && Tx !== lvl[bi]) bad = 1'b1;
            end
          end
          if (!aborted) begin
            vectors++;
            if (bad) begin
              miscompares++;
              $display("FAIL tx frame waveform: byte 0x%0h not serialized as required (div %0d, par %0d)",
                       b, m_div, m_par_en);
            end
            tx_done++;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete, %0d vectors, %0d miscompares", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  b;
    logic [7:0]  pend[$];
    int          div;
    bit          pe, odd;

    // Reset state
    repeat (3) @(negedge PCLK);
    check("reset Tx", {31'd0, Tx}, 32'd1);
    check("reset IRQ", {31'd0, IRQ}, 32'd0);
    check("reset PSLVERR", {31'd0, PSLVERR}, 32'd0);
    check("reset PRDATA", PRDATA, 32'd0);
    PRESET = 1'b0;
    rd(8'h08, st_exp(), 1'b0);
    rd(8'h0C, 32'd0, 1'b0);
    rd(8'h10, 32'd867, 1'b0);

    // TX-empty interrupt follows CTRL
    wr(8'h0C, 32'h20, 1'b0);
    repeat (2) @(negedge PCLK);
    check("irq txe", {31'd0, IRQ}, 32'd1);
    wr(8'h0C, 32'h00, 1'b0);
    repeat (2) @(negedge PCLK);
    check("irq off", {31'd0, IRQ}, 32'd0);

    // Single 0xA5 frame at BAUDDIV=3
    wr(8'h10, 32'd3, 1'b0);
    m_div = 3; m_par_en = 1'b0; m_par_odd = 1'b0;
    wr(8'h0C, 32'h01, 1'b0);
    tx_exp_q.push_back(8'hA5);
    wr(8'h00, 32'hA5, 1'b0);
    wait_tx(1, 200);

    // Fill the TX FIFO with transmission disabled; the 17th write must error
    wr(8'h0C, 32'h00, 1'b0);
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'($urandom);
      if (i < DEPTH) begin
        wr(8'h00, {24'hABCDEF, b}, 1'b0);
        pend.push_back(b);
        m_tx_cnt++;
      end else begin
        wr(8'h00, {24'd0, b}, 1'b1);
      end
    end
    rd(8'h08, st_exp(), 1'b0);
    rd(8'h28, st_exp(), 1'b0);
    rd(8'h00, 32'd0, 1'b1);
    wr(8'h04, 32'h55, 1'b1);
    rd(8'h04, 32'd0, 1'b1);
    rd(8'h14, 32'd0, 1'b1);
    wr(8'h1C, 32'h1, 1'b1);

    // Drain it
    foreach (pend[i]) tx_exp_q.push_back(pend[i]);
    wr(8'h0C, 32'h01, 1'b0);
    wait_tx(1 + DEPTH, DEPTH * 60);
    m_tx_cnt = 0;
    rd(8'h08, st_exp(), 1'b0);

    // Loopback with random divisors and parity modes
    loop_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        b = 8'h3C; pe = 1'b1; odd = 1'b1; div = 3;
      end else begin
        b = 8'($urandom); pe = 1'($urandom_range(1, 0)); odd = 1'($urandom_range(1, 0));
        div = $urandom_range(6, 3);
      end
      wr(8'h10, div, 1'b0);
      m_div = div; m_par_en = pe; m_par_odd = odd;
      wr(8'h0C, {28'd0, odd, pe, 2'b11}, 1'b0);
      tx_exp_q.push_back(b);
      wr(8'h00, {24'd0, b}, 1'b0);
      wait_tx(tx_done + 1, 20 * (div + 1));
      repeat (3 * (div + 1)) @(negedge PCLK);
      rx_model_push(b);
      rd(8'h04, {24'd0, rx_model.pop_front()}, 1'b0);
      rd(8'h08, st_exp(), 1'b0);
    end
    wr(8'h0C, 32'h00, 1'b0);
    loop_en = 1'b0;

    // Overrun: 17 frames with no reads
    wr(8'h10, 32'd3, 1'b0);
    m_div = 3;
    wr(8'h0C, 32'h02, 1'b0);
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b0, 1'b0, 1'b0, 1'b1);
      rx_model_push(b);
    end
    rd(8'h08, st_exp(), 1'b0);
    for (int i = 0; i < DEPTH; i++) rd(8'h04, {24'd0, rx_model.pop_front()}, 1'b0);
    rd(8'h04, 32'd0, 1'b1);
    wr(8'h08, 32'h10, 1'b0);
    m_ovr = 1'b0;
    rd(8'h08, st_exp(), 1'b0);

    // Parity error: byte kept, sticky flag set, W1C clears it
    wr(8'h0C, 32'h06, 1'b0);
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b0, 1'b1, 1'b1);
    rx_model_push(b);
    m_perr = 1'b1;
    rd(8'h08, st_exp(), 1'b0);
    rd(8'h04, {24'd0, rx_model.pop_front()}, 1'b0);
    wr(8'h08, 32'h20, 1'b0);
    m_perr = 1'b0;
    rd(8'h08, st_exp(), 1'b0);

    // Frame error: byte discarded, error interrupt raised
    wr(8'h0C, 32'h42, 1'b0);
    send_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    m_ferr = 1'b1;
    rd(8'h08, st_exp(), 1'b0);
    check("irq frame_err", {31'd0, IRQ}, 32'd1);
    wr(8'h08, 32'h40, 1'b0);
    m_ferr = 1'b0;
    repeat (2) @(negedge PCLK);
    check("irq cleared", {31'd0, IRQ}, 32'd0);
    rd(8'h08, st_exp(), 1'b0);

    // Reset pulse during the DATA bits of a frame
    tx_mon_en = 1'b0;
    wr(8'h0C, 32'h01, 1'b0);
    wr(8'h00, {24'd0, 8'($urandom)}, 1'b0);
    repeat (8) @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("Tx after mid-frame reset", {31'd0, Tx}, 32'd1);
    PRESET = 1'b0;
    rx_model.delete();
    m_tx_cnt = 0; m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
    @(negedge PCLK);
    check("Tx idle after reset", {31'd0, Tx}, 32'd1);
    rd(8'h08, st_exp(), 1'b0);
    rd(8'h0C, 32'd0, 1'b0);
    rd(8'h10, 32'd867, 1'b0);
    tx_mon_en = 1'b1;

    repeat (4) @(negedge PCLK);
    check("apb expectations consumed", apb_q.size(), 32'd0);
    check("tx expectations consumed", tx_exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
